uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
- Serial receiver, 8N1 (optional parity), LSB first; recovers bytes from an asynchronous rx line.
- Emits each good byte with a one-cycle strobe.
- Sits directly upstream of the team's word shift-register stage:
  - byteOut drives its wordIn.
  - byteValid drives its shiftEnable.
- Result: every received character is pushed into the character buffer.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); must be >= 4.
- WIDTH, 8, data bits per frame.
- SYNC_STAGES, 2, flops in rx metastability synchronizer; must be >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset. Clock is clk.
- rx  in  1  asynchronous serial line; idles high.
- byteOut  out  WIDTH  last good received byte; held until the next good byte.
- byteValid  out  1  one-cycle pulse when byteOut is updated.
- frameError  out  1  one-cycle pulse on a bad stop bit (or bad parity if enabled).
- busy  out  1  high while not in IDLE.

Behaviour:
- Synchronizer: rx passes through SYNC_STAGES flops, all reset to 1. Call the synchronized signal rxs; all logic below uses rxs.
- Bit-timing counter: bitCnt, width ceil(log2(CLKS_PER_BIT)). Bit index counter: 0..WIDTH-1.
- States:
  - IDLE: busy=0. On rxs==0, clear the counter and go to START.
  - START: count to CLKS_PER_BIT/2-1 (integer division), which is mid start bit. Sample rxs:
    - 0: clear the counter and index, go to DATA.
    - 1: glitch; return to IDLE with no output.
  - DATA: every CLKS_PER_BIT cycles, sample rxs into shift register bit [index], LSB first. After index WIDTH-1 is sampled, go to STOP (or PARITY if enabled).
  - STOP: after CLKS_PER_BIT cycles, sample rxs:
    - 1: next cycle byteOut <= assembled byte, byteValid=1 for exactly one cycle, go to IDLE.
    - 0: next cycle frameError=1 for one cycle, byteOut unchanged, go to BREAK.
  - BREAK: wait until rxs==1, then go to IDLE. A held-low line (break) yields exactly one frameError.
- Latency: byteValid rises 1 clk after the mid-stop sample. That is about (WIDTH+1.5)*CLKS_PER_BIT + SYNC_STAGES + 1 cycles after the rx falling edge.
- Back-to-back frames: a start bit arriving half a bit after the mid-stop sample is detected. Re-entering IDLE takes 1 cycle, so no idle gap is required.
- byteValid and frameError are never high in the same cycle.
- Reset:
  - Reset values: byteOut=0, byteValid=0, frameError=0, busy=0, state=IDLE, counters=0, synchronizer=1.
  - Reset mid-frame aborts the frame with no strobe.
  - If rx is low when reset releases, the block enters START only after the synchronizer has flushed.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even) and a PARITY state between DATA and STOP. The state samples one bit after CLKS_PER_BIT cycles.
  - Mismatch with the computed parity: the frame still completes its stop-bit sample, then frameError pulses instead of byteValid.
- Undefined:
  - No PARITY state; frames are 8N1 and PARITY_ODD is absent.
  - Ports are identical in both builds.

Test Plan (CLKS_PER_BIT=16, WIDTH=8):
- Single frame 0xA5, ideal timing -> byteOut=0xA5; byteValid high exactly 1 cycle; frameError=0; busy low afterwards.
- Back-to-back 0x48,0x69 with no idle gap -> two byteValid pulses 160 cycles apart; byteOut=0x48 then 0x69.
- rx low for 5 cycles then high (glitch) -> no byteValid, no frameError, busy returns to 0 within 8 cycles of the low pulse ending.
- Frame 0x3C with stop bit driven 0, then line held low 100 cycles, then high -> exactly one frameError pulse; byteOut keeps its previous value; next frame 0x7E is received correctly.
- Reset asserted at mid data bit 3 of frame 0xFF, released, then frame 0x01 -> no strobe for the aborted frame; byteOut=0x01 with one byteValid.
- With UART_RX_PARITY_EN defined, PARITY_ODD=0: frame 0x07 with parity bit 1 -> byteValid. Same frame with parity bit 0 -> frameError, no byteValid.

Source files
------------

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver with an rx metastability synchronizer.
// Recovers one WIDTH-bit character per frame, LSB first, and emits it with a
// one-cycle byteValid strobe; a bad stop bit produces a one-cycle frameError.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit between the last
// data bit and the stop bit (PARITY_ODD selects odd parity, default even).
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434,
    parameter int WIDTH        = 8,
    parameter int SYNC_STAGES  = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD   = 0
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    output logic [WIDTH-1:0] byteOut,
    output logic             byteValid,
    output logic             frameError,
    output logic             busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_ZERO = IW'(0);
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;

    state_t           r_state, w_state_nx;
    logic [CW-1:0]    r_cnt,   w_cnt_nx;
    logic [IW-1:0]    r_idx,   w_idx_nx;
    logic [WIDTH-1:0] r_shift, w_shift_nx;
    logic [WIDTH-1:0] r_byte,  w_byte_nx;
    logic             r_valid, w_valid_nx;
    logic             r_ferr,  w_ferr_nx;
    logic             r_busy;
`ifdef UART_RX_PARITY_EN
    logic             r_perr,  w_perr_nx;
`endif

    assign w_rxs      = r_sync[SYNC_STAGES-1];
    assign byteOut    = r_byte;
    assign byteValid  = r_valid;
    assign frameError = r_ferr;
    assign busy       = r_busy;

    // Metastability synchronizer for the asynchronous rx line; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{1'b1}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    // State register plus all datapath registers and the registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
            r_idx   <= IDX_ZERO;
            r_shift <= {WIDTH{1'b0}};
            r_byte  <= {WIDTH{1'b0}};
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
            r_byte  <= w_byte_nx;
            r_valid <= w_valid_nx;
            r_ferr  <= w_ferr_nx;
            r_busy  <= (w_state_nx != S_IDLE);
`ifdef UART_RX_PARITY_EN
            r_perr  <= w_perr_nx;
`endif
        end
    end

    // Next-state and datapath decode; strobes default low so they last one cycle.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_byte_nx  = r_byte;
        w_valid_nx = 1'b0;
        w_ferr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_nx  = r_perr;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_rxs == 1'b0) begin
                    w_cnt_nx   = CNT_ZERO;
                    w_state_nx = S_START;
                end else begin
                    w_cnt_nx   = r_cnt;
                end
            end
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    // Mid start bit: a high line here was only a glitch.
                    if (w_rxs == 1'b0) begin
                        w_cnt_nx   = CNT_ZERO;
                        w_idx_nx   = IDX_ZERO;
                        w_state_nx = S_DATA;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx          = CNT_ZERO;
                    w_shift_nx[r_idx] = w_rxs;
                    if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nx = S_PARITY;
`else
                        w_state_nx = S_STOP;
`endif
                    end else begin
                        w_idx_nx = r_idx + IDX_ONE;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx   = CNT_ZERO;
                    w_perr_nx  = (^r_shift) ^ w_rxs ^ PAR_ODD_BIT;
                    w_state_nx = S_STOP;
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nx = CNT_ZERO;
                    if (w_rxs == 1'b1) begin
                        w_state_nx = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (r_perr) begin
                            w_ferr_nx = 1'b1;
                        end else begin
                            w_valid_nx = 1'b1;
                            w_byte_nx  = r_shift;
                        end
`else
                        w_valid_nx = 1'b1;
                        w_byte_nx  = r_shift;
`endif
                    end else begin
                        // Bad stop bit: report once, then wait out any break.
                        w_ferr_nx  = 1'b1;
                        w_state_nx = S_BREAK;
                    end
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
            S_BREAK: begin
                if (w_rxs == 1'b1) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = S_BREAK;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = CNT_ZERO;
                w_idx_nx   = IDX_ZERO;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte at CLKS_PER_BIT=16, WIDTH=8. Stimulus pushes the
// expected strobe (good byte or frame error) into a queue; a monitor process
// pops and compares each time the DUT raises byteValid or frameError.
module tb_uart_rx_byte;

    localparam int BIT = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_CYC = 11 * BIT;
`else
    localparam int FRAME_CYC = 10 * BIT;
`endif

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] byteOut;
    logic       byteValid;
    logic       frameError;
    logic       busy;

    exp_t       q[$];
    int         n_pass  = 0;
    int         n_total = 0;
    int         n_valid = 0;
    int         n_ferr  = 0;
    int         cyc     = 0;
    int         t_valid_last = 0;
    int         t_valid_prev = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ferr  = 1'b0;
    logic [7:0] exp_last;

    uart_rx_byte #(
        .CLKS_PER_BIT(BIT),
        .WIDTH(8),
        .SYNC_STAGES(2)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ODD(0)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .byteOut(byteOut),
        .byteValid(byteValid),
        .frameError(frameError),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every strobe against the scoreboard, check pulse widths.
    always @(negedge clk) begin
        exp_t e;
        if (prev_valid) check("valid_width", {31'd0, byteValid}, 32'd0);
        if (prev_ferr)  check("ferr_width",  {31'd0, frameError}, 32'd0);
        if (byteValid && frameError) check("valid_ferr_exclusive", 32'd1, 32'd0);
        if (byteValid || frameError) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", {30'd0, byteValid, frameError}, 32'd0);
            end else begin
                e = q.pop_front();
                check("strobe_kind", {31'd0, frameError}, {31'd0, e.is_err});
                check("strobe_byteOut", {24'd0, byteOut}, {24'd0, e.data});
            end
        end
        if (byteValid) begin
            n_valid++;
            t_valid_prev = t_valid_last;
            t_valid_last = cyc;
        end
        if (frameError) n_ferr++;
        prev_valid = byteValid;
        prev_ferr  = frameError;
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // One frame: start, 8 data bits LSB first, optional parity, stop.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(d[i], BIT);
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ par_flip, BIT);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        hold(stop_bit, BIT);
    endtask

    task automatic expect_byte(input logic [7:0] d);
        q.push_back('{is_err: 1'b0, data: d});
        exp_last = d;
    endtask

    task automatic expect_err();
        q.push_back('{is_err: 1'b1, data: exp_last});
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (q.size() != 0 && k < 4 * FRAME_CYC) begin
            @(negedge clk);
            k++;
        end
        check(name, q.size(), 32'd0);
    endtask

    initial begin
        int nv;
        int nf;
        reset = 1'b1;
        rx    = 1'b1;
        exp_last = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_byteOut", {24'd0, byteOut}, 32'd0);
        check("reset_valid", {31'd0, byteValid}, 32'd0);
        check("reset_ferr", {31'd0, frameError}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        hold(1'b1, 5);

        // Single ideal frame.
        expect_byte(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        drain("a5_drain");
        check("a5_busy_after", {31'd0, busy}, 32'd0);
        hold(1'b1, 10);

        // Back-to-back frames with no idle gap.
        expect_byte(8'h48);
        send_frame(8'h48, 1'b1, 1'b0);
        expect_byte(8'h69);
        send_frame(8'h69, 1'b1, 1'b0);
        drain("b2b_drain");
        check("b2b_interval", t_valid_last - t_valid_prev, FRAME_CYC);
        hold(1'b1, 10);

        // Five-cycle glitch: no strobe, busy back low within 8 cycles.
        nv = n_valid;
        nf = n_ferr;
        hold(1'b0, 5);
        hold(1'b1, 8);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        hold(1'b1, 20);
        check("glitch_no_valid", n_valid, nv);
        check("glitch_no_ferr", n_ferr, nf);

        // Bad stop bit then a 100-cycle break: exactly one frameError.
        nf = n_ferr;
        expect_err();
        send_frame(8'h3C, 1'b0, 1'b0);
        hold(1'b0, 100);
        hold(1'b1, 20);
        drain("break_drain");
        check("break_one_ferr", n_ferr, nf + 1);
        check("break_byteOut_held", {24'd0, byteOut}, 32'h69);
        expect_byte(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0);
        drain("after_break_drain");
        hold(1'b1, 10);

        // Reset in mid data bit 3 of an 0xFF frame.
        nv = n_valid;
        hold(1'b0, BIT);
        hold(1'b1, 3 * BIT + BIT / 2);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_last = 8'h00;
        hold(1'b1, 4 * FRAME_CYC);
        check("abort_no_valid", n_valid, nv);
        check("abort_byteOut_reset", {24'd0, byteOut}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        expect_byte(8'h01);
        send_frame(8'h01, 1'b1, 1'b0);
        drain("after_abort_drain");
        check("after_abort_one_valid", n_valid, nv + 1);
        hold(1'b1, 10);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 with parity bit 1 is good, with 0 is an error.
        expect_byte(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        drain("par_good_drain");
        hold(1'b1, 10);
        nv = n_valid;
        expect_err();
        send_frame(8'h07, 1'b1, 1'b1);
        drain("par_bad_drain");
        check("par_bad_no_valid", n_valid, nv);
        hold(1'b1, 10);
`endif

        hold(1'b1, 50);
        check("scoreboard_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
